input_debouncer: RTL and testbench

//  Conditions raw board inputs (BTNC/U/D/L/R, SW[15:0]) before they reach the

---
 rtl/input_debouncer_pkg.sv | 22 ++
 rtl/input_debouncer_cell.sv | 60 ++++++
 rtl/input_debouncer.sv | 59 +++++
 tb/tb_input_debouncer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared constants for the board input conditioner: default timing and the
// button/switch bit map used when wiring PORTI/PORTJ.
package input_debouncer_pkg;

    localparam int DEB_PRESCALE_1MHZ = 1000;
    localparam int DEB_STABLE        = 5;

    localparam int BTN_C   = 0;
    localparam int BTN_D   = 1;
    localparam int BTN_U   = 2;
    localparam int BTN_R   = 3;
    localparam int BTN_L   = 4;
    localparam int SW_LSB  = 5;
    localparam int SW_MSB  = 20;
    localparam int DEB_WIDTH = SW_MSB + 1;

    // Counter wide enough to hold STABLE_TICKS-1 with a spare bit.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks) + 1;
    endfunction

endpackage

// File: rtl/input_debouncer_cell.sv
// One conditioned input: 2-FF synchroniser, tick-gated debounce counter,
// single-cycle rise/fall pulses and a sticky change flag.
module input_debouncer_cell
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEB_STABLE
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    input  logic clr,
    output logic state,
    output logic rise,
    output logic fall,
    output logic changed
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            state   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            changed <= 1'b0;
        end else begin
            // stage p0/p1: synchroniser; only sync_p1 feeds the debounce logic
            sync_p0 <= raw;
            sync_p1 <= sync_p0;

            rise <= 1'b0;
            fall <= 1'b0;
            // A pulse arriving with clr still sets the flag so no event is lost.
            changed <= (changed & ~clr) | rise | fall;

            if (tick) begin
                if (sync_p1 == state) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    state <= sync_p1;
                    cnt   <= '0;
                    rise  <= sync_p1;
                    fall  <= ~sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Board input conditioner: shared sample-tick prescaler feeding WIDTH
// debounce cells, plus the OR of the sticky change flags as an IRQ source.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH        = DEB_WIDTH,
    parameter int PRESCALE     = DEB_PRESCALE_1MHZ,
    parameter int STABLE_TICKS = DEB_STABLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] changed,
    output logic             tick,
    output logic             irq
);

    localparam int PCNT_W = $clog2(PRESCALE);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pcnt == PCNT_LAST);
            if (pcnt == PCNT_LAST) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        input_debouncer_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .raw     (raw[i]),
            .tick    (tick),
            .clr     (clr[i]),
            .state   (state[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .changed (changed[i])
        );
    end

    assign irq = |changed;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with a small cycle-level reference model.
module tb_input_debouncer;

    localparam int W  = 4;
    localparam int P  = 4;
    localparam int ST = 3;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] raw   = '0;
    logic [W-1:0] clr   = '0;
    logic [W-1:0] state, rise, fall, changed;
    logic         tick, irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .WIDTH(W), .PRESCALE(P), .STABLE_TICKS(ST)
    ) dut (
        .clk(clk), .reset(reset), .raw(raw), .clr(clr),
        .state(state), .rise(rise), .fall(fall), .changed(changed),
        .tick(tick), .irq(irq)
    );

    // Reference model: ticks fall every P clocks after release; an input
    // is accepted once ST consecutive tick samples (seen 2 clocks late)
    // disagree with the accepted level.
    typedef struct packed {
        logic [7:0] run;
        logic       level;
        logic       pulse;
    } bstep_t;

    function automatic bstep_t bit_step(input logic tk, input logic smp,
                                        input logic level, input logic [7:0] run);
        bstep_t o;
        o.run   = run;
        o.level = level;
        o.pulse = 1'b0;
        if (tk) begin
            if (smp == level) begin
                o.run = 8'd0;
            end else begin
                o.run = run + 8'd1;
                if (int'(o.run) == ST) begin
                    o.run   = 8'd0;
                    o.level = smp;
                    o.pulse = 1'b1;
                end
            end
        end
        return o;
    endfunction

    logic [W-1:0] d1, d2, m_state, m_rise, m_fall, m_changed;
    logic         m_tick;
    logic [7:0]   m_run [W];
    int           m_edges;
    bstep_t       nxt [W];

    always_comb begin
        for (int i = 0; i < W; i++) begin
            nxt[i] = bit_step(m_tick, d2[i], m_state[i], m_run[i]);
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1 <= '0; d2 <= '0;
            m_state <= '0; m_rise <= '0; m_fall <= '0; m_changed <= '0;
            m_tick <= 1'b0; m_edges <= 0;
            for (int i = 0; i < W; i++) m_run[i] <= 8'd0;
        end else begin
            for (int i = 0; i < W; i++) begin
                m_run[i]   <= nxt[i].run;
                m_state[i] <= nxt[i].level;
                m_rise[i]  <= nxt[i].pulse & nxt[i].level;
                m_fall[i]  <= nxt[i].pulse & ~nxt[i].level;
            end
            m_changed <= (m_changed & ~clr) | m_rise | m_fall;
            m_tick    <= ((m_edges + 1) % P) == 0;
            m_edges   <= m_edges + 1;
            d2 <= d1;
            d1 <= raw;
        end
    end

    logic [4*W+1:0] dut_vec, mdl_vec;
    assign dut_vec = {state, rise, fall, changed, tick, irq};
    assign mdl_vec = {m_state, m_rise, m_fall, m_changed, m_tick, |m_changed};

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first_full;
        int rcnt [W];
        first_full = -1;
        for (int i = 0; i < W; i++) rcnt[i] = 0;
        reset = 1'b0; raw = '1; clr = '0;
        cyc(); cyc();
        checks++;
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", dut_vec);
        end
        reset = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL t1_model n=%0d got=%h exp=%h", n, dut_vec, mdl_vec);
            end
            for (int i = 0; i < W; i++) rcnt[i] += int'(rise[i]);
            if (first_full < 0 && state === '1) first_full = n;
        end
        checks++;
        if (first_full != P + 1 + (ST - 1) * P) begin
            failures++;
            $display("FAIL t1_latency got=%0d exp=%0d", first_full, P + 1 + (ST - 1) * P);
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (rcnt[i] != 1) begin
                failures++;
                $display("FAIL t1_rise_count bit=%0d got=%0d exp=1", i, rcnt[i]);
            end
        end
        checks++;
        if (changed !== 4'hF || irq !== 1'b1) begin
            failures++;
            $display("FAIL t1_changed got=%h/%b exp=f/1", changed, irq);
        end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = 0;
        raw = '0;
        repeat (20) cyc();
        clr = '1; cyc(); clr = '0; cyc();
        raw[0] = 1'b1;
        repeat (3) cyc();
        raw[0] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL t2_model n=%0d got=%h exp=%h", n, dut_vec, mdl_vec);
            end
            r0 += int'(rise[0]);
        end
        checks++;
        if (r0 != 0 || state[0] !== 1'b0) begin
            failures++;
            $display("FAIL t2_glitch rises=%0d state0=%b exp=0/0", r0, state[0]);
        end
    endtask

    task automatic test_bounce();
        int rb, rh, t_up;
        bit seen;
        rb = 0; rh = 0; t_up = -1; seen = 0;
        for (int n = 0; n < 2 * P && !seen; n++) begin
            cyc();
            if (tick === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL t3_tick_wait got=0 exp=1");
        end
        for (int k = 0; k < 20; k++) begin
            raw[1] = ((k / 2) % 2) == 0;
            cyc();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL t3_model_bounce k=%0d got=%h exp=%h", k, dut_vec, mdl_vec);
            end
            rb += int'(rise[1]);
        end
        raw[1] = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL t3_model_hold n=%0d got=%h exp=%h", n, dut_vec, mdl_vec);
            end
            rh += int'(rise[1]);
            if (t_up < 0 && state[1] === 1'b1) t_up = n;
        end
        checks++;
        if (rb != 0 || rh != 1) begin
            failures++;
            $display("FAIL t3_rise_count bounce=%0d hold=%0d exp=0/1", rb, rh);
        end
        checks++;
        if (t_up < 3 + (ST - 1) * P || t_up > 2 + ST * P) begin
            failures++;
            $display("FAIL t3_latency got=%0d exp=%0d..%0d", t_up, 3 + (ST - 1) * P, 2 + ST * P);
        end
    endtask

    task automatic test_clr();
        bit seen;
        clr = '1; cyc(); clr = '0;
        raw[0] = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            cyc();
            if (rise[0] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL t4_rise_wait got=0 exp=1");
        end
        cyc(); cyc();
        clr = '1; cyc(); clr = '0; cyc();
        checks++;
        if (changed !== 4'h0) begin
            failures++;
            $display("FAIL t4_cleared got=%h exp=0", changed);
        end
        raw[0] = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            cyc();
            if (fall[0] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL t4_fall_wait got=0 exp=1");
        end
        clr = 4'h1;
        cyc();
        checks++;
        if (changed[0] !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL t4_set_wins got=%b/%b exp=1/1", changed[0], irq);
        end
        cyc();
        clr = '0;
        checks++;
        if (changed[0] !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL t4_clear got=%b/%b exp=0/0", changed[0], irq);
        end
    endtask

    task automatic test_reset_abort();
        int r2, t_up;
        r2 = 0; t_up = -1;
        raw[2] = 1'b1;
        for (int n = 0; n < 2 * P + 2; n++) begin
            cyc();
            r2 += int'(rise[2]);
        end
        checks++;
        if (r2 != 0 || state[2] !== 1'b0) begin
            failures++;
            $display("FAIL t5_pre_reset rises=%0d state2=%b exp=0/0", r2, state[2]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            failures++;
            $display("FAIL t5_async_clear got=%h exp=0", dut_vec);
        end
        cyc();
        reset = 1'b1;
        r2 = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL t5_model n=%0d got=%h exp=%h", n, dut_vec, mdl_vec);
            end
            r2 += int'(rise[2]);
            if (t_up < 0 && state[2] === 1'b1) t_up = n;
        end
        checks++;
        if (t_up != P + 1 + (ST - 1) * P || r2 != 1) begin
            failures++;
            $display("FAIL t5_restart t=%0d rises=%0d exp=%0d/1", t_up, r2, P + 1 + (ST - 1) * P);
        end
    endtask

    task automatic test_tick_period();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            cyc();
            checks++;
            if (tick !== ((n % P) == 0)) begin
                failures++;
                $display("FAIL t6_tick n=%0d got=%b exp=%b", n, tick, (n % P) == 0);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 1;
        for (int n = 0; n < 400; n++) begin
            hold--;
            if (hold == 0) begin
                raw  = raw ^ W'($urandom_range(1, (1 << W) - 1));
                hold = $urandom_range(1, 16);
            end
            clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            cyc();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL t7_random n=%0d got=%h exp=%h", n, dut_vec, mdl_vec);
            end
        end
        clr = '0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
        test_clr();
        test_reset_abort();
        test_tick_period();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
